// File: rtl/mc_arb_pkg.sv
// Shared types for the memory-port arbiter: core count, core index and the
// access sequencer state encoding.
package mc_arb_pkg;

   localparam int NUM_CORES = 4;

   typedef logic [1:0] core_idx_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } arb_state_t;

   function automatic logic [NUM_CORES-1:0] core_onehot(input core_idx_t idx);
      logic [NUM_CORES-1:0] vec;
      vec = '0;
      vec[idx] = 1'b1;
      return vec;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_picker.sv
// Round-robin winner selection: first requesting core at or after ptr,
// searching upward and wrapping from the top core back to core 0.
module rr_picker
   import mc_arb_pkg::*;
(
   input  logic [NUM_CORES-1:0] req,
   input  core_idx_t            ptr,
   output logic                 grant_valid,
   output core_idx_t            grant_idx
);

   core_idx_t cand;

   // Walk from the farthest offset down so the nearest requester is written last.
   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = ptr;
      cand        = ptr;
      for (int i = NUM_CORES - 1; i >= 0; i--) begin
         cand = ptr + core_idx_t'(i);
         if (req[cand]) begin
            grant_valid = 1'b1;
            grant_idx   = cand;
         end
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Four-core arbiter for the controller's single-port data memory, plus the
// all-cores-done collector that feeds the controller's state-advance logic.
//
// state | meaning
// IDLE  | no access in flight; pick a winner when any req is high
// ISSUE | mem_en high for one cycle with the latched request; load wait timer
// WAIT  | wait timer counts down to terminal count, then read data is captured
// RESP  | ack strobe to the winner; round-robin pointer moves past it
module mem_port_arbiter
   import mc_arb_pkg::*;
#(
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 16,
   parameter int MEM_LAT = 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_CORES-1:0]          req,
   input  logic [NUM_CORES-1:0]          we,
   input  logic [NUM_CORES*ADDR_W-1:0]   addr,
   input  logic [NUM_CORES*DATA_W-1:0]   wdata,
   output logic [NUM_CORES-1:0]          ack,
   output logic [DATA_W-1:0]             rdata,
   output logic                          mem_en,
   output logic                          mem_we,
   output logic [ADDR_W-1:0]             mem_addr,
   output logic [DATA_W-1:0]             mem_wdata,
   input  logic [DATA_W-1:0]             mem_rdata,
   input  logic [NUM_CORES-1:0]          op_end,
   output logic                          all_done,
   output logic [NUM_CORES-1:0]          done_mask
);

   localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

   arb_state_t           state_q, state_d;
   core_idx_t            ptr_q;
   core_idx_t            win_idx_q;
   logic [CNT_W-1:0]     wait_cnt_q;

   logic                 pick_valid;
   core_idx_t            pick_idx;

   logic [ADDR_W-1:0]    addr_arr  [NUM_CORES];
   logic [DATA_W-1:0]    wdata_arr [NUM_CORES];

   logic                 grant_load;
   logic                 cnt_load;
   logic                 cnt_dec;
   logic                 cnt_tc;
   logic                 resp_enter;
   logic                 resp_active;

   logic [NUM_CORES-1:0] done_nxt;

   always_comb begin
      for (int i = 0; i < NUM_CORES; i++) begin
         addr_arr[i]  = addr[i*ADDR_W +: ADDR_W];
         wdata_arr[i] = wdata[i*DATA_W +: DATA_W];
      end
   end

   rr_picker u_rr_picker (
      .req         (req),
      .ptr         (ptr_q),
      .grant_valid (pick_valid),
      .grant_idx   (pick_idx)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   assign cnt_tc = (wait_cnt_q == '0);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (pick_valid) state_d = ISSUE;
         ISSUE:   state_d = WAIT;
         WAIT:    if (cnt_tc) state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      grant_load  = 1'b0;
      cnt_load    = 1'b0;
      cnt_dec     = 1'b0;
      resp_enter  = 1'b0;
      resp_active = 1'b0;
      unique case (state_q)
         IDLE:    grant_load  = pick_valid;
         ISSUE:   cnt_load    = 1'b1;
         WAIT: begin
            cnt_dec    = !cnt_tc;
            resp_enter = cnt_tc;
         end
         RESP:    resp_active = 1'b1;
         default: ;
      endcase
   end

   // The mem_* registers double as the latched request, so they only move on ISSUE entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q      <= '0;
         win_idx_q  <= '0;
         wait_cnt_q <= '0;
         ack        <= '0;
         rdata      <= '0;
         mem_en     <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
      end else begin
         mem_en <= grant_load;
         if (grant_load) begin
            win_idx_q <= pick_idx;
            mem_we    <= we[pick_idx];
            mem_addr  <= addr_arr[pick_idx];
            mem_wdata <= wdata_arr[pick_idx];
         end

         if (cnt_load) begin
            wait_cnt_q <= CNT_LOAD;
         end else if (cnt_dec) begin
            wait_cnt_q <= wait_cnt_q - CNT_W'(1);
         end

         ack <= resp_enter ? core_onehot(win_idx_q) : '0;
         if (resp_enter && !mem_we) begin
            rdata <= mem_rdata;
         end

         if (resp_active) begin
            ptr_q <= win_idx_q + core_idx_t'(1);
         end
      end
   end

   assign done_nxt = done_mask | op_end;

   // The op_end bits that complete the set are consumed by the pulse, not carried over.
   always_ff @(posedge clk) begin
      if (rst) begin
         done_mask <= '0;
         all_done  <= 1'b0;
      end else if (&done_nxt) begin
         done_mask <= '0;
         all_done  <= 1'b1;
      end else begin
         done_mask <= done_nxt;
         all_done  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: MEM_LAT=1 instance for arbitration,
// data and done tracking, MEM_LAT=3 instance for the longer wait path.
module tb_mem_port_arbiter;

   logic clk;
   logic rst;
   int   cyc = 0;

   logic [3:0]  req, we, ack, op_end, done_mask;
   logic [31:0] addr;
   logic [63:0] wdata;
   logic [15:0] rdata, mem_wdata, mem_rdata, rd1;
   logic        mem_en, mem_we, all_done;
   logic [7:0]  mem_addr;
   logic [15:0] mem1 [256];

   logic [3:0]  req3, we3, ack3, op_end3, done_mask3;
   logic [31:0] addr3;
   logic [63:0] wdata3;
   logic [15:0] rdata3, mem_wdata3, mem_rdata3, s0, s1, s2;
   logic        mem_en3, mem_we3, all_done3;
   logic [7:0]  mem_addr3;

   typedef struct {
      int          core;
      logic        we;
      logic [7:0]  addr;
      logic [15:0] wdata;
      logic [15:0] rdata;
      int          ack_cyc;
   } sb_t;

   sb_t         sb [$];
   logic [15:0] exp_rd;
   int          n_chk = 0;
   int          n_err = 0;
   int          c0;

   mem_port_arbiter #(.ADDR_W(8), .DATA_W(16), .MEM_LAT(1)) dut (
      .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .ack(ack), .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .op_end(op_end), .all_done(all_done), .done_mask(done_mask)
   );

   mem_port_arbiter #(.ADDR_W(8), .DATA_W(16), .MEM_LAT(3)) dut3 (
      .clk(clk), .rst(rst), .req(req3), .we(we3), .addr(addr3), .wdata(wdata3),
      .ack(ack3), .rdata(rdata3), .mem_en(mem_en3), .mem_we(mem_we3),
      .mem_addr(mem_addr3), .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3),
      .op_end(op_end3), .all_done(all_done3), .done_mask(done_mask3)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [15:0] pat(input logic [7:0] a);
      return (a == 8'h10) ? 16'h1234 : {8'hA5, a};
   endfunction

   // Memory behind the MEM_LAT=1 instance: one-cycle read, write on mem_en & mem_we.
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 256; i++) mem1[i] <= pat(8'(i));
         rd1 <= '0;
      end else if (mem_en) begin
         if (mem_we) mem1[mem_addr] <= mem_wdata;
         rd1 <= mem1[mem_addr];
      end
   end
   assign mem_rdata = rd1;

   // Read-only memory behind the MEM_LAT=3 instance: three register stages.
   always @(posedge clk) begin
      if (mem_en3) s0 <= pat(mem_addr3);
      s1 <= s0;
      s2 <= s1;
   end
   assign mem_rdata3 = s2;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic set_core(input int i, input logic w, input logic [7:0] a, input logic [15:0] d);
      we[i]           = w;
      addr[i*8 +: 8]  = a;
      wdata[i*16 +: 16] = d;
   endtask

   task automatic push(input int core, input logic w, input logic [7:0] a,
                       input logic [15:0] d, input int ack_cyc);
      sb_t e;
      e.core  = core;
      e.we    = w;
      e.addr  = a;
      e.wdata = d;
      if (!w) exp_rd = (a == 8'h20) ? 16'hBEEF : pat(a);
      e.rdata   = exp_rd;
      e.ack_cyc = ack_cyc;
      sb.push_back(e);
   endtask

   // Watches the bus each cycle: checks issues against the head entry, pops on ack
   // and drops the acked core's request.
   task automatic run_sb(input int budget);
      sb_t e;
      int  n;
      n = 0;
      while (sb.size() > 0 && n < budget) begin
         @(negedge clk);
         n++;
         if (mem_en) begin
            chk("issue_cyc",  32'(cyc), 32'(sb[0].ack_cyc - 2));
            chk("issue_we",   32'(mem_we), 32'(sb[0].we));
            chk("issue_addr", 32'(mem_addr), 32'(sb[0].addr));
            if (sb[0].we) chk("issue_wdata", 32'(mem_wdata), 32'(sb[0].wdata));
         end
         if (ack != 4'b0) begin
            e = sb.pop_front();
            chk("ack_core",  32'(ack), 32'(4'b0001 << e.core));
            chk("ack_cyc",   32'(cyc), 32'(e.ack_cyc));
            chk("ack_rdata", 32'(rdata), 32'(e.rdata));
            req = req & ~ack;
         end
      end
      if (sb.size() > 0) begin
         chk("sb_timeout", 32'(sb.size()), 32'd0);
         sb.delete();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int ack_seen;
      int en_cnt, en_cyc, ack_cyc3;
      logic [15:0] rd3;

      rst = 1'b1;
      req = '0; we = '0; addr = '0; wdata = '0; op_end = '0;
      req3 = '0; we3 = '0; addr3 = '0; wdata3 = '0; op_end3 = '0;
      exp_rd = '0;
      repeat (3) @(negedge clk);
      chk("rst_ack",       32'(ack), 32'd0);
      chk("rst_rdata",     32'(rdata), 32'd0);
      chk("rst_mem_en",    32'(mem_en), 32'd0);
      chk("rst_mem_we",    32'(mem_we), 32'd0);
      chk("rst_mem_addr",  32'(mem_addr), 32'd0);
      chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
      chk("rst_done_mask", 32'(done_mask), 32'd0);
      chk("rst_all_done",  32'(all_done), 32'd0);
      chk("rst3_outputs",  32'({ack3, mem_en3, mem_we3, all_done3, done_mask3}), 32'd0);
      chk("rst3_data",     32'({rdata3, mem_wdata3}), 32'd0);
      rst = 1'b0;

      // Single read from core 2
      @(negedge clk);
      c0 = cyc;
      set_core(2, 1'b0, 8'h10, 16'h0);
      req[2] = 1'b1;
      push(2, 1'b0, 8'h10, 16'h0, c0 + 3);
      run_sb(20);

      // Four simultaneous reads from reset, twice: order 0,1,2,3 both times
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_rd = '0;
      for (int rep = 0; rep < 2; rep++) begin
         @(negedge clk);
         c0 = cyc;
         for (int i = 0; i < 4; i++) begin
            set_core(i, 1'b0, 8'(8'h01 + i + 4 * rep), 16'h0);
            push(i, 1'b0, 8'(8'h01 + i + 4 * rep), 16'h0, c0 + 3 + 4 * i);
         end
         req = 4'hF;
         run_sb(40);
      end

      // Core 3 writes 0x20, core 0 then reads it back
      @(negedge clk);
      c0 = cyc;
      set_core(3, 1'b1, 8'h20, 16'hBEEF);
      req[3] = 1'b1;
      push(3, 1'b1, 8'h20, 16'hBEEF, c0 + 3);
      @(negedge clk);
      chk("wr_issue_en",    32'(mem_en), 32'd1);
      chk("wr_issue_we",    32'(mem_we), 32'd1);
      chk("wr_issue_wdata", 32'(mem_wdata), 32'hBEEF);
      set_core(0, 1'b0, 8'h20, 16'h0);
      req[0] = 1'b1;
      push(0, 1'b0, 8'h20, 16'h0, c0 + 7);
      run_sb(30);

      // Core 1 access moves ptr to 2, then reset in WAIT of a core 2 access
      @(negedge clk);
      c0 = cyc;
      set_core(1, 1'b0, 8'h30, 16'h0);
      req[1] = 1'b1;
      push(1, 1'b0, 8'h30, 16'h0, c0 + 3);
      run_sb(20);
      @(negedge clk);
      set_core(2, 1'b0, 8'h40, 16'h0);
      req[2] = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      req = '0;
      @(negedge clk);
      rst = 1'b0;
      exp_rd = '0;
      chk("rstw_ack",    32'(ack), 32'd0);
      chk("rstw_mem_en", 32'(mem_en), 32'd0);
      chk("rstw_rdata",  32'(rdata), 32'd0);
      ack_seen = 0;
      repeat (4) begin
         @(negedge clk);
         if (ack != 4'b0) ack_seen++;
      end
      chk("rstw_no_ack", 32'(ack_seen), 32'd0);
      @(negedge clk);
      c0 = cyc;
      set_core(1, 1'b0, 8'h41, 16'h0);
      set_core(2, 1'b0, 8'h42, 16'h0);
      req = 4'b0110;
      push(1, 1'b0, 8'h41, 16'h0, c0 + 3);
      push(2, 1'b0, 8'h42, 16'h0, c0 + 7);
      run_sb(30);

      // Done tracking
      @(negedge clk);
      op_end = 4'b0001;
      @(negedge clk);
      chk("done_m1", 32'(done_mask), 32'h1);
      chk("done_a1", 32'(all_done), 32'd0);
      op_end = 4'b0110;
      @(negedge clk);
      chk("done_m2", 32'(done_mask), 32'h7);
      chk("done_a2", 32'(all_done), 32'd0);
      op_end = 4'b1000;
      @(negedge clk);
      chk("done_a3", 32'(all_done), 32'd1);
      chk("done_m3", 32'(done_mask), 32'h0);
      op_end = 4'b0000;
      @(negedge clk);
      chk("done_pulse_end", 32'(all_done), 32'd0);
      chk("done_m4", 32'(done_mask), 32'h0);
      op_end = 4'b1111;
      @(negedge clk);
      chk("done_all_a", 32'(all_done), 32'd1);
      chk("done_all_m", 32'(done_mask), 32'h0);
      op_end = 4'b0010;
      @(negedge clk);
      chk("done_during_a", 32'(all_done), 32'd0);
      chk("done_during_m", 32'(done_mask), 32'h2);
      op_end = 4'b1101;
      @(negedge clk);
      chk("done_fill_a", 32'(all_done), 32'd1);
      op_end = 4'b0000;
      @(negedge clk);
      chk("done_final", 32'({all_done, done_mask}), 32'd0);

      // MEM_LAT=3 read from core 1
      @(negedge clk);
      c0 = cyc;
      we3[1] = 1'b0;
      addr3[15:8] = 8'h05;
      req3[1] = 1'b1;
      en_cnt = 0; en_cyc = -1; ack_cyc3 = -1; rd3 = '0;
      repeat (10) begin
         @(negedge clk);
         if (mem_en3) begin
            en_cnt++;
            en_cyc = cyc;
            chk("lat3_addr", 32'(mem_addr3), 32'h05);
         end
         if (ack3 != 4'b0) begin
            chk("lat3_ack_core", 32'(ack3), 32'h2);
            ack_cyc3 = cyc;
            rd3 = rdata3;
            req3 = req3 & ~ack3;
         end
      end
      chk("lat3_en_count", 32'(en_cnt), 32'd1);
      chk("lat3_en_cyc",   32'(en_cyc), 32'(c0 + 1));
      chk("lat3_ack_cyc",  32'(ack_cyc3), 32'(c0 + 5));
      chk("lat3_rdata",    32'(rd3), 32'hA505);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
